tx_arbiter: RTL

- Round-robin scheduler that shares one serial data transmitter between NUM_REQ producers, e.g. the microsecond counter snapshot and test patterns.
- Captures one requester's word and issues a single-cycle send pulse to the transmitter.
- Tracks the transmitter's busy handshake.
- Enforces an inter-frame gap before the next arbitration.

---
 rtl/tx_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin scheduler that shares one serial transmitter
// between NUM_REQ producers. Captures the winner's payload, pulses tx_send,
// follows the transmitter's busy handshake and enforces an inter-frame gap.
// Optional build macro TX_ARBITER_TAG_EN: when defined, the top $clog2(NUM_REQ)
// bits of tx_data carry the granted index instead of payload bits.
module tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 64,
  parameter int GAP_CYCLES    = 16,
  parameter int START_TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          tx_send,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]    active_id,
  output logic                          timeout,
  output logic                          idle
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(START_TIMEOUT - 1);
  localparam logic [GW-1:0] G_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT_START, S_WAIT_DONE, S_GAP
  } state_t;

  state_t                state, state_nxt;
  logic [IW-1:0]         rr_ptr;
  logic [TW-1:0]         start_cnt;
  logic [GW-1:0]         gap_cnt;
  logic [IW-1:0]         pick_idx;
  logic                  pick_vld;
  logic                  capture;
  logic                  to_fire;
  logic [DATA_WIDTH-1:0] cap_data;

  // Counters hold at all-ones instead of wrapping.
  function automatic logic [TW-1:0] sat_inc_t(input logic [TW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [GW-1:0] sat_inc_g(input logic [GW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // First requester at or above rr_ptr, wrapping around.
  always_comb begin
    int j;
    j        = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!pick_vld && req[j]) begin
        pick_vld = 1'b1;
        pick_idx = IW'(j);
      end
    end
  end

  // Payload of the winner, optionally tagged with its index for demux.
  always_comb begin
    cap_data = req_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
`ifdef TX_ARBITER_TAG_EN
    cap_data[DATA_WIDTH-1 -: IW] = pick_idx;
`else
`endif
  end

  // Next-state and strobe decode.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    to_fire   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!tx_busy && pick_vld) begin
          capture   = 1'b1;
          state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: state_nxt = S_WAIT_START;
      S_WAIT_START: begin
        if (tx_busy) begin
          state_nxt = S_WAIT_DONE;
        end else if (start_cnt == T_LAST) begin
          to_fire   = 1'b1;
          state_nxt = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) state_nxt = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        if (gap_cnt == G_LAST) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Registered outputs, capture, round-robin pointer and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant     <= '0;
      tx_send   <= 1'b0;
      timeout   <= 1'b0;
      tx_data   <= '0;
      active_id <= '0;
      rr_ptr    <= '0;
      start_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      grant   <= capture ? (NUM_REQ'(1) << pick_idx) : '0;
      tx_send <= (state == S_LAUNCH);
      timeout <= to_fire;
      if (capture) begin
        tx_data   <= cap_data;
        active_id <= pick_idx;
        rr_ptr    <= (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
      end
      if (state == S_LAUNCH)          start_cnt <= '0;
      else if (state == S_WAIT_START) start_cnt <= sat_inc_t(start_cnt);
      if (state_nxt == S_GAP && state != S_GAP) gap_cnt <= '0;
      else if (state == S_GAP)                  gap_cnt <= sat_inc_g(gap_cnt);
    end
  end

  assign idle = (state == S_IDLE);

endmodule
